// File: rtl/lif_neuron_cell.sv
// Leaky integrate-and-fire neuron tile with a daisy-chained serial config slice.
// Integrates signed weighted spikes into an 8-bit clamped membrane with leak, threshold and refractory period.
module lif_neuron_cell #(
  parameter  int N_IN    = 4,
  localparam int CFG_LEN = 4*N_IN + 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            config_en,
  input  logic            bs_in,
  output logic            bs_out,
  input  logic [N_IN-1:0] spike_in,
  output logic            spike_out,
  output logic [7:0]      membrane
);

  localparam int SUM_W = 12;

  logic [CFG_LEN-1:0]      cfg;
  logic [1:0]              refr_cnt;

  logic                    enable;
  logic [1:0]              refr;
  logic [2:0]              leak;
  logic [7:0]              thr;

  logic [7:0]              leak_term;
  logic signed [3:0]       w;
  logic signed [SUM_W-1:0] w_ext;
  logic signed [SUM_W-1:0] in_sum;
  logic signed [SUM_W-1:0] next_raw;
  logic [7:0]              next_mem;
  logic                    fire;

  assign enable = cfg[CFG_LEN-1];
  assign refr   = cfg[CFG_LEN-2 -: 2];
  assign leak   = cfg[CFG_LEN-4 -: 3];
  assign thr    = cfg[4*N_IN +: 8];
  assign bs_out = cfg[CFG_LEN-1];

  always_comb begin
    w      = '0;
    w_ext  = '0;
    in_sum = '0;
    if (refr_cnt == 2'd0) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        w     = cfg[4*i +: 4];
        w_ext = {{(SUM_W-4){w[3]}}, w};
        if (spike_in[i]) in_sum = in_sum + w_ext;
      end
    end
  end

  always_comb begin
    leak_term = (leak == 3'd0) ? '0 : (membrane >> leak);
    next_raw  = $signed({{(SUM_W-8){1'b0}}, membrane})
              - $signed({{(SUM_W-8){1'b0}}, leak_term})
              + in_sum;
    // Sign bit means underflow; any set bit above [7] means overflow.
    if (next_raw[SUM_W-1])
      next_mem = '0;
    else if (|next_raw[SUM_W-2:8])
      next_mem = '1;
    else
      next_mem = next_raw[7:0];
    fire = (refr_cnt == 2'd0) && (thr != 8'd0) && (next_mem >= thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {cfg[CFG_LEN-2:0], bs_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      membrane  <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= '0;
    end else if (config_en || !enable) begin
      membrane  <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= '0;
    end else if (fire) begin
      membrane  <= '0;
      spike_out <= 1'b1;
      refr_cnt  <= refr;
    end else begin
      membrane  <= next_mem;
      spike_out <= 1'b0;
      if (refr_cnt != 2'd0) refr_cnt <= refr_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_lif_neuron_cell.sv
// Scoreboard bench for lif_neuron_cell: an integer reference model predicts each edge's outputs, a monitor compares.
module tb_lif_neuron_cell;

  logic       clk;
  logic       rst_n;
  logic       config_en;
  logic       bs_in;
  logic       bs_out;
  logic [3:0] spike_in;
  logic       spike_out;
  logic [7:0] membrane;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  logic [29:0] m_cfg;
  int          m_mem;
  int          m_rc;
  bit          m_spk;

  lif_neuron_cell #(.N_IN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .spike_in  (spike_in),
    .spike_out (spike_out),
    .membrane  (membrane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int weight(input logic [29:0] c, input int idx);
    logic signed [3:0] v;
    int r;
    v = c[4*idx +: 4];
    r = v;
    return r;
  endfunction

  function automatic logic [29:0] mk_cfg(input int en, input int refr, input int leak, input int thr,
                                         input int w3, input int w2, input int w1, input int w0);
    logic [29:0] c;
    c[29]    = en[0];
    c[28:27] = refr[1:0];
    c[26:24] = leak[2:0];
    c[23:16] = thr[7:0];
    c[15:12] = w3[3:0];
    c[11:8]  = w2[3:0];
    c[7:4]   = w1[3:0];
    c[3:0]   = w0[3:0];
    return c;
  endfunction

  task automatic model_reset();
    m_cfg = '0;
    m_mem = 0;
    m_rc  = 0;
    m_spk = 1'b0;
  endtask

  // Applies one clock edge's behaviour to the model using the current (pre-edge) config.
  task automatic model_edge(input logic cen, input logic bin, input logic [3:0] sin);
    int thr, leak, refr, sum, leak_amt, nxt;
    if (cen || !m_cfg[29]) begin
      m_mem = 0;
      m_spk = 1'b0;
      m_rc  = 0;
    end else begin
      refr = m_cfg[28:27];
      leak = m_cfg[26:24];
      thr  = m_cfg[23:16];
      sum  = 0;
      if (m_rc == 0)
        for (int i = 0; i < 4; i++) if (sin[i]) sum += weight(m_cfg, i);
      leak_amt = (leak == 0) ? 0 : m_mem / (2 ** leak);
      nxt = m_mem - leak_amt + sum;
      if (nxt < 0) nxt = 0;
      if (nxt > 255) nxt = 255;
      if (m_rc == 0 && thr != 0 && nxt >= thr) begin
        m_spk = 1'b1;
        m_mem = 0;
        m_rc  = refr;
      end else begin
        m_spk = 1'b0;
        m_mem = nxt;
        if (m_rc > 0) m_rc--;
      end
    end
    if (cen) m_cfg = {m_cfg[28:0], bin};
  endtask

  // Called at posedge+2: drive inputs, predict the coming edge, wait for it.
  task automatic step(input logic cen, input logic bin, input logic [3:0] sin);
    config_en = cen;
    bs_in     = bin;
    spike_in  = sin;
    model_edge(cen, bin, sin);
    exp_q.push_back({m_mem[7:0], m_spk, m_cfg[29]});
    @(posedge clk);
    #2;
  endtask

  task automatic load_cfg(input logic [29:0] c);
    for (int i = 29; i >= 0; i--) step(1'b1, c[i], 4'b0000);
  endtask

  task automatic run(input int n, input logic [3:0] sin);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, sin);
  endtask

  task automatic direct_check(input string name, input logic [9:0] want);
    checks++;
    if ({membrane, spike_out, bs_out} !== want) begin
      errors++;
      $display("FAIL %s got mem=%0d spk=%b bso=%b want mem=%0d spk=%b bso=%b",
               name, membrane, spike_out, bs_out, want[9:2], want[1], want[0]);
    end
  endtask

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({membrane, spike_out, bs_out} !== e) begin
          errors++;
          $display("FAIL edge@%0t got mem=%0d spk=%b bso=%b want mem=%0d spk=%b bso=%b",
                   $time, membrane, spike_out, bs_out, e[9:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  sin;
    logic [29:0] rc;
    rst_n     = 1'b0;
    config_en = 1'b0;
    bs_in     = 1'b0;
    spike_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    direct_check("reset_state", 10'd0);
    rst_n = 1'b1;

    // Chain pass-through, then frozen when config_en drops.
    load_cfg(30'h2AAAAAAA);
    load_cfg(30'h0);
    load_cfg(30'h2AAAAAAA);
    run(5, 4'b0000);
    load_cfg(30'h0);

    // Integrate and fire every 4 cycles.
    load_cfg(mk_cfg(1, 0, 0, 20, 0, 0, 0, 5));
    run(12, 4'b0001);

    // Leak reaches steady state 14.
    load_cfg(mk_cfg(1, 0, 1, 0, 0, 0, 0, 7));
    run(8, 4'b0001);

    // Clamp high, then drain to zero.
    load_cfg(mk_cfg(1, 0, 0, 0, 0, 0, -8, 7));
    run(40, 4'b0001);
    run(36, 4'b0010);

    // Refractory period of 2.
    load_cfg(mk_cfg(1, 2, 0, 10, 0, 0, 0, 5));
    run(12, 4'b0001);

    // One-cycle config_en mid-integration restarts from rest and shifts the chain.
    load_cfg(mk_cfg(1, 0, 0, 20, 0, 0, 0, 5));
    run(3, 4'b0001);
    step(1'b1, 1'b1, 4'b0001);
    run(4, 4'b0001);

    // Async reset mid-run clears outputs before the next edge and the config thereafter.
    load_cfg(mk_cfg(1, 0, 0, 200, 3, 3, 3, 3));
    run(4, 4'b1111);
    rst_n = 1'b0;
    #1;
    direct_check("async_reset", 10'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    run(4, 4'b1111);

    // Randomized configurations and spike patterns, with occasional config_en glitches.
    for (int t = 0; t < 8; t++) begin
      rc = $urandom();
      rc[29] = 1'b1;
      if ($urandom_range(0, 3) != 0) rc[23:16] = 8'($urandom_range(1, 60));
      load_cfg(rc);
      for (int k = 0; k < 60; k++) begin
        sin = 4'($urandom());
        if ($urandom_range(0, 49) == 0) step(1'b1, 1'($urandom()), sin);
        else step(1'b0, 1'b0, sin);
      end
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
